// File: rtl/comp_iter.sv
// Iterative magnitude comparator: scans two WIDTH-bit operands CHUNK bits per
// cycle from the MSB down, stops on the first differing chunk, holds the flags.
module comp_iter #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             out_valid,
  output logic             eq,
  output logic             neq,
  output logic             gt,
  output logic             geq,
  output logic             lt,
  output logic             leq
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]    IDX_TOP  = IW'(N - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [1:0] {R_EQ, R_GT, R_LT} res_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] ca, cb;
  logic             accept, decide;
  res_t             res;

  // Chunk mux with constant slices; only the chunk matching idx is selected.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        ca = a_r[i*CHUNK +: CHUNK];
        cb = b_r[i*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    res = R_EQ;
    if (ca > cb)      res = R_GT;
    else if (ca < cb) res = R_LT;
  end

  assign accept = (state == IDLE) && in_valid;
  assign decide = (state == SCAN) && ((ca != cb) || (idx == '0));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SCAN;
      SCAN:    if (decide)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      // NOTE: operand registers are reset too; they are only a few flops and
      // this keeps simulation free of X on the idle chunk mux.
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      eq    <= 1'b0;
      neq   <= 1'b0;
      gt    <= 1'b0;
      geq   <= 1'b0;
      lt    <= 1'b0;
      leq   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Flipping the sign bit maps two's complement onto unsigned order.
        a_r <= signed_mode ? (a ^ MSB_MASK) : a;
        b_r <= signed_mode ? (b ^ MSB_MASK) : b;
        idx <= IDX_TOP;
      end else if ((state == SCAN) && !decide) begin
        idx <= idx - 1'b1;
      end
      if (decide) begin
        eq  <= (res == R_EQ);
        neq <= (res != R_EQ);
        gt  <= (res == R_GT);
        geq <= (res != R_LT);
        lt  <= (res == R_LT);
        leq <= (res != R_GT);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

endmodule
